// File: rtl/pixel_stream_receiver.sv
// Deserialises the debounced Pi bit stream into a HEIGHT x WIDTH x CHANNELS sample memory.
// Optional running checksum output is enabled by defining PIXEL_STREAM_CHECKSUM_EN.
module pixel_stream_receiver #(
  parameter int HEIGHT    = 20,
  parameter int WIDTH     = 30,
  parameter int CHANNELS  = 3,
  parameter int BITS      = 8,
  parameter int MSB_FIRST = 1,
  localparam int TOTAL    = HEIGHT * WIDTH * CHANNELS,
  localparam int AW       = $clog2(TOTAL)
) (
  input  logic            slow_clk,
  input  logic            dbnc_rst,
  input  logic            pi_clk_s,
  input  logic            data_s,
  input  logic            wr_en_s,
  input  logic            frame_start,
  input  logic [AW-1:0]   rd_addr,
  output logic [BITS-1:0] rd_data,
  output logic [AW:0]     sample_count,
  output logic            frame_done,
  output logic            overflow,
  output logic            busy
`ifdef PIXEL_STREAM_CHECKSUM_EN
  ,
  output logic [15:0]     checksum
`endif
);

  localparam int BCW = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_t;

  state_t          state;
  logic            pi_prev;
  logic [BCW-1:0]  bit_cnt;
  logic [BITS-1:0] buffer;
  logic [BITS-1:0] mem [TOTAL];

  logic            pi_edge;
  logic            capture;
  logic            last_bit;
  logic            last_sample;
  logic            mem_we;
  logic [BCW-1:0]  shamt;
  logic [BITS-1:0] next_buf;

  // A bit is taken on a Pi clock rising edge with write enable; frame_start always wins.
  assign pi_edge     = pi_clk_s & ~pi_prev;
  assign capture     = pi_edge & wr_en_s & ~frame_start & (state != DONE);
  assign last_bit    = (bit_cnt == BCW'(BITS - 1));
  assign last_sample = (sample_count == (AW + 1)'(TOTAL - 1));
  assign mem_we      = capture & last_bit;
  assign shamt       = (MSB_FIRST != 0) ? (BCW'(BITS - 1) - bit_cnt) : bit_cnt;
  assign next_buf    = buffer | (BITS'(data_s) << shamt);

  always_ff @(posedge slow_clk or posedge dbnc_rst) begin
    if (dbnc_rst) begin
      state        <= IDLE;
      pi_prev      <= 1'b1;
      bit_cnt      <= '0;
      buffer       <= '0;
      sample_count <= '0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      pi_prev <= pi_clk_s;
      if (frame_start) begin
        state        <= RECV;
        bit_cnt      <= '0;
        buffer       <= '0;
        sample_count <= '0;
        frame_done   <= 1'b0;
        overflow     <= 1'b0;
        busy         <= 1'b1;
      end else begin
        if (capture) begin
          if (last_bit) begin
            bit_cnt      <= '0;
            buffer       <= '0;
            sample_count <= sample_count + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            buffer  <= next_buf;
          end
        end else if (state == RECV && !wr_en_s) begin
          bit_cnt <= '0;
          buffer  <= '0;
        end

        case (state)
          IDLE, RECV: begin
            if (mem_we && last_sample) begin
              state      <= DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else if (capture) begin
              state <= RECV;
              busy  <= 1'b1;
            end
          end
          DONE: begin
            if (pi_edge && wr_en_s) begin
              overflow <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sample memory carries no reset so it maps onto block RAM.
  always_ff @(posedge slow_clk) begin
    if (mem_we) begin
      mem[sample_count[AW-1:0]] <= next_buf;
    end
  end

  always_ff @(posedge slow_clk or posedge dbnc_rst) begin
    if (dbnc_rst) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} < (AW + 1)'(TOTAL)) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

`ifdef PIXEL_STREAM_CHECKSUM_EN
  always_ff @(posedge slow_clk or posedge dbnc_rst) begin
    if (dbnc_rst) begin
      checksum <= '0;
    end else if (frame_start) begin
      checksum <= '0;
    end else if (mem_we) begin
      checksum <= checksum + 16'(next_buf);
    end
  end
`else
  // Without the checksum the receiver keeps no running sum.
`endif

endmodule
